// File: rtl/fsic_wb_axil_bridge.sv
// Wishbone-classic slave to AXI4-Lite master bridge: one single access in flight, no bursts.
// Optional macro FSIC_WB_TIMEOUT_EN adds a per-transaction timeout that forces an error ack.
module fsic_wb_axil_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK   = 32'hFFFF_0000,
  parameter int          AXI_ADDR_W  = 15,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst_n,
  input  logic [31:0]           wbs_adr,
  input  logic [31:0]           wbs_wdata,
  input  logic [3:0]            wbs_sel,
  input  logic                  wbs_cyc,
  input  logic                  wbs_stb,
  input  logic                  wbs_we,
  output logic                  wbs_ack,
  output logic [31:0]           wbs_rdata,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [AXI_ADDR_W-1:0] m_awaddr,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  output logic [31:0]           m_wdata,
  output logic [3:0]            m_wstrb,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  input  logic [1:0]            m_bresp,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [AXI_ADDR_W-1:0] m_araddr,
  input  logic                  m_rvalid,
  output logic                  m_rready,
  input  logic [31:0]           m_rdata,
  input  logic [1:0]            m_rresp,
  output logic                  err_sticky,
  input  logic                  err_clr,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_ACK
  } state_e;

  if (TIMEOUT_CYC < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e                state_q, state_d;
  logic [AXI_ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            sel_q, sel_d;
  logic                  we_q, we_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  abort_q, abort_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  req_hit;
  logic                  new_err;

`ifdef FSIC_WB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  assign req_hit = wbs_cyc && wbs_stb && ((wbs_adr & ADDR_MASK) == BASE_ADDR);

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d   = state_q;
    adr_d     = adr_q;
    wdata_d   = wdata_q;
    sel_d     = sel_q;
    we_d      = we_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    abort_d   = abort_q;
    rdata_d   = rdata_q;
    new_err   = 1'b0;
`ifdef FSIC_WB_TIMEOUT_EN
    tmo_d     = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        abort_d   = 1'b0;
`ifdef FSIC_WB_TIMEOUT_EN
        tmo_d     = '0;
`endif
        if (req_hit) begin
          adr_d   = wbs_adr[AXI_ADDR_W-1:0];
          wdata_d = wbs_wdata;
          sel_d   = wbs_sel;
          we_d    = wbs_we;
          state_d = wbs_we ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        // AW and W are accepted independently; move on once both have been taken.
        if (m_awready) aw_done_d = 1'b1;
        if (m_wready)  w_done_d  = 1'b1;
        if ((aw_done_q || m_awready) && (w_done_q || m_wready)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        if (m_bvalid) begin
          new_err = (m_bresp != 2'b00);
          state_d = S_ACK;
        end
      end
      S_RD_REQ: begin
        if (m_arready) state_d = S_RD_RESP;
      end
      S_RD_RESP: begin
        if (m_rvalid) begin
          rdata_d = m_rdata;
          new_err = (m_rresp != 2'b00);
          state_d = S_ACK;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A master that abandons the cycle still lets the AXI side finish, but gets no ack.
    if (state_q != S_IDLE && state_q != S_ACK && !wbs_cyc) abort_d = 1'b1;

`ifdef FSIC_WB_TIMEOUT_EN
    if (state_q != S_IDLE && state_q != S_ACK) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        new_err = 1'b1;
        state_d = S_ACK;
        if (!we_q) rdata_d = 32'hFFFF_FFFF;
      end
    end
`endif

    err_d = err_q;
    if (err_clr) err_d = 1'b0;
    if (new_err) err_d = 1'b1;
  end

  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!wb_rst_n) begin
      state_q   <= S_IDLE;
      adr_q     <= '0;
      wdata_q   <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef FSIC_WB_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      wdata_q   <= wdata_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      abort_q   <= abort_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef FSIC_WB_TIMEOUT_EN
      tmo_q     <= tmo_d;
`endif
    end
  end

  // Handshake outputs decode straight from registered state, so reset clears them at once.
  assign m_awvalid  = (state_q == S_WR_REQ) && !aw_done_q;
  assign m_wvalid   = (state_q == S_WR_REQ) && !w_done_q;
  assign m_bready   = (state_q == S_WR_RESP);
  assign m_arvalid  = (state_q == S_RD_REQ);
  assign m_rready   = (state_q == S_RD_RESP);
  assign m_awaddr   = adr_q;
  assign m_araddr   = adr_q;
  assign m_wdata    = wdata_q;
  assign m_wstrb    = sel_q;
  assign wbs_ack    = (state_q == S_ACK) && !abort_q;
  assign wbs_rdata  = (wbs_ack && !we_q) ? rdata_q : 32'h0;
  assign err_sticky = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
